// File: rtl/barcode_frame_serializer.sv
// barcode_frame_serializer: turns one accepted pricing result (d, value_to_pay)
// into a framed bar/space pattern with quiet zones, start/stop guards and an
// even-parity bit. Each module is held for MODULE_CYCLES clocks.
module barcode_frame_serializer #(
  parameter int MODULE_CYCLES = 4,
  parameter int QUIET_MODULES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] value_to_pay,
  input  logic [3:0] d,
  input  logic       p_n,
  output logic       bar_out,
  output logic       bar_active,
  output logic       frame_done,
  output logic       reject
);

  localparam int CW = (MODULE_CYCLES > 1) ? $clog2(MODULE_CYCLES) : 1;
  localparam int MQ = (QUIET_MODULES > 3) ? QUIET_MODULES : 3;
  localparam int MW = $clog2(MQ);
  localparam logic [CW-1:0] CYC_LAST   = CW'(MODULE_CYCLES - 1);
  localparam logic [MW-1:0] QUIET_LAST = MW'(QUIET_MODULES - 1);
  localparam logic [MW-1:0] TRIPLE_LAST = MW'(2);

  typedef enum logic [2:0] {
    IDLE, QUIET_PRE, START, DATA, STOP, QUIET_POST
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cyc, cyc_nxt;
  logic [MW-1:0] mod_idx, mod_nxt;
  logic [3:0]    sym, sym_nxt;
  logic [9:0]    payload;
  logic [9:0]    payload_sel;
  logic          armed;
  logic          handshake;
  logic          module_end;
  logic          bar_nxt;

  // Even parity: 1 when the nine data bits hold an odd number of ones.
  function automatic logic parity9(input logic [8:0] bits);
    return ^bits;
  endfunction

  // Level of the module addressed by (state, module index, current data bit).
  function automatic logic module_level(input state_t s, input logic [MW-1:0] m,
                                        input logic bitv);
    case (s)
      START, STOP: return (m != MW'(1));
      DATA:        return (m == '0) || ((m == MW'(1)) && bitv);
      default:     return 1'b0;
    endcase
  endfunction

  // armed keeps in_ready low until the first clock edge after reset release.
  assign in_ready   = armed && (state == IDLE);
  assign handshake  = in_valid && in_ready;
  assign bar_active = (state != IDLE);
  assign frame_done = (state == QUIET_POST) && (mod_idx == QUIET_LAST) && (cyc == CYC_LAST);
  assign module_end = (cyc == CYC_LAST);
  assign payload_sel = payload << sym_nxt;

  // Next-state and sub-counter sequencing; bar level is precomputed for the next cycle.
  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc;
    mod_nxt   = mod_idx;
    sym_nxt   = sym;
    if (state == IDLE) begin
      if (handshake && !p_n) begin
        state_nxt = QUIET_PRE;
        cyc_nxt   = '0;
        mod_nxt   = '0;
        sym_nxt   = '0;
      end
    end else if (!module_end) begin
      cyc_nxt = cyc + 1'b1;
    end else begin
      cyc_nxt = '0;
      mod_nxt = mod_idx + 1'b1;
      unique case (state)
        QUIET_PRE: if (mod_idx == QUIET_LAST) begin
          state_nxt = START;
          mod_nxt   = '0;
        end
        START: if (mod_idx == TRIPLE_LAST) begin
          state_nxt = DATA;
          mod_nxt   = '0;
          sym_nxt   = '0;
        end
        DATA: if (mod_idx == TRIPLE_LAST) begin
          mod_nxt = '0;
          if (sym == 4'd9) begin
            state_nxt = STOP;
            sym_nxt   = '0;
          end else begin
            sym_nxt = sym + 1'b1;
          end
        end
        STOP: if (mod_idx == TRIPLE_LAST) begin
          state_nxt = QUIET_POST;
          mod_nxt   = '0;
        end
        QUIET_POST: if (mod_idx == QUIET_LAST) begin
          state_nxt = IDLE;
          mod_nxt   = '0;
        end
        default: state_nxt = IDLE;
      endcase
    end
    bar_nxt = module_level(state_nxt, mod_nxt, payload_sel[9]);
  end

  // State, counters, captured payload and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cyc     <= '0;
      mod_idx <= '0;
      sym     <= '0;
      payload <= '0;
      bar_out <= 1'b0;
      reject  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cyc     <= cyc_nxt;
      mod_idx <= mod_nxt;
      sym     <= sym_nxt;
      bar_out <= bar_nxt;
      reject  <= handshake && p_n;
      armed   <= 1'b1;
      if (handshake) payload <= {d, value_to_pay, parity9({d, value_to_pay})};
    end
  end

endmodule

// File: tb/tb_barcode_frame_serializer.sv
// Scoreboard bench for barcode_frame_serializer: expected per-cycle bar levels
// are queued at each handshake and popped while the DUT reports bar_active.
module tb_barcode_frame_serializer;

  localparam int MC = 4;
  localparam int QM = 2;
  localparam int FLEN = (2 * QM + 36) * MC;

  typedef struct packed { logic bar; logic last; } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] value_to_pay = '0;
  logic [3:0] d = '0;
  logic       p_n = 1'b0;
  logic       bar_out, bar_active, frame_done, reject;

  logic       in_valid1 = 1'b0;
  logic       in_ready1;
  logic [4:0] value_to_pay1 = '0;
  logic [3:0] d1 = '0;
  logic       p_n1 = 1'b0;
  logic       bar_out1, bar_active1, frame_done1, reject1;

  exp_t q0[$];
  int   checks = 0;
  int   errors = 0;

  barcode_frame_serializer #(.MODULE_CYCLES(MC), .QUIET_MODULES(QM)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .value_to_pay(value_to_pay), .d(d), .p_n(p_n), .bar_out(bar_out),
    .bar_active(bar_active), .frame_done(frame_done), .reject(reject));

  barcode_frame_serializer #(.MODULE_CYCLES(1), .QUIET_MODULES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .value_to_pay(value_to_pay1), .d(d1), .p_n(p_n1), .bar_out(bar_out1),
    .bar_active(bar_active1), .frame_done(frame_done1), .reject(reject1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference frame: module i of the frame is bit i of the result.
  function automatic logic [63:0] model(input logic [3:0] dd, input logic [4:0] vv, input int qm);
    logic [63:0] m;
    logic [9:0]  s;
    int          k;
    int          ones;
    m = '0;
    s = {dd, vv, 1'b0};
    ones = 0;
    for (int i = 1; i < 10; i++) ones += int'(s[i]);
    s[0] = (ones % 2) == 1;
    k = qm;
    m[k] = 1'b1; m[k+2] = 1'b1; k += 3;
    for (int i = 9; i >= 0; i--) begin
      m[k] = 1'b1; m[k+1] = s[i]; k += 3;
    end
    m[k] = 1'b1; m[k+2] = 1'b1;
    return m;
  endfunction

  task automatic push_modules(input logic [63:0] m, input int nmod);
    for (int i = 0; i < nmod; i++)
      for (int c = 0; c < MC; c++)
        q0.push_back('{bar: m[i], last: (i == nmod - 1) && (c == MC - 1)});
  endtask

  // Module stream for d=0101, value_to_pay=10011 written out by hand.
  task automatic push_literal();
    logic [39:0] lit;
    logic [63:0] m;
    lit = 40'b00_101_100_110_100_110_110_100_100_110_110_110_101_00;
    m = '0;
    for (int i = 0; i < 40; i++) m[i] = lit[39-i];
    push_modules(m, 40);
  endtask

  // Called at a negedge; returns at the negedge of the first frame cycle.
  task automatic send(input logic [3:0] dd, input logic [4:0] vv, input bit lit, input bit hold);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    chk("ready_wait", in_ready, 1'b1);
    in_valid = 1'b1; d = dd; value_to_pay = vv; p_n = 1'b0;
    if (lit) push_literal(); else push_modules(model(dd, vv, QM), 2 * QM + 36);
    @(posedge clk); #1;
    d = 4'($urandom); value_to_pay = 5'($urandom);
    if (!hold) in_valid = 1'b0;
    @(negedge clk);
    chk("latency_active", bar_active, 1'b1);
  endtask

  task automatic wait_done(input int exp_len);
    int n;
    n = 1;
    while (frame_done !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    chk("done_seen", frame_done, 1'b1);
    chk("frame_len", n, exp_len);
  endtask

  task automatic idle_check();
    @(negedge clk);
    chk("ready_after", in_ready, 1'b1);
    chk("idle_after", bar_active, 1'b0);
  endtask

  // Scoreboard monitor for the default-parameter instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bar_active) begin
        if (q0.size() == 0) chk("extra_active", bar_active, 1'b0);
        else begin
          exp_t e;
          e = q0.pop_front();
          chk("bar_out", bar_out, e.bar);
          chk("frame_done", frame_done, e.last);
        end
      end else begin
        chk("done_idle", frame_done, 1'b0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] m1;
    repeat (3) @(negedge clk);
    chk("rst_bar_out", bar_out, 1'b0);
    chk("rst_bar_active", bar_active, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_reject", reject, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", in_ready, 1'b1);

    send(4'b0101, 5'b10011, 1'b1, 1'b0);
    wait_done(FLEN);
    idle_check();

    send(4'b0000, 5'b00000, 1'b0, 1'b0);
    wait_done(FLEN);
    idle_check();

    in_valid = 1'b1; p_n = 1'b1; d = 4'b1010; value_to_pay = 5'b11100;
    @(posedge clk); #1;
    in_valid = 1'b0; p_n = 1'b0;
    @(negedge clk);
    chk("reject_pulse", reject, 1'b1);
    chk("reject_inactive", bar_active, 1'b0);
    chk("reject_ready", in_ready, 1'b1);
    @(negedge clk);
    chk("reject_single", reject, 1'b0);
    chk("reject_inactive2", bar_active, 1'b0);

    send(4'b1100, 5'b00101, 1'b0, 1'b1);
    wait_done(FLEN);
    d = 4'b0011; value_to_pay = 5'b11010; p_n = 1'b0;
    push_modules(model(4'b0011, 5'b11010, QM), 2 * QM + 36);
    @(negedge clk);
    chk("b2b_gap_idle", bar_active, 1'b0);
    chk("b2b_gap_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_second_active", bar_active, 1'b1);
    wait_done(FLEN);
    idle_check();

    send(4'b1110, 5'b01010, 1'b0, 1'b0);
    repeat (49) @(negedge clk);
    chk("pre_reset_bar", bar_out, 1'b1);
    #2;
    rst_n = 1'b0;
    q0.delete();
    #1;
    chk("async_bar_out", bar_out, 1'b0);
    chk("async_bar_active", bar_active, 1'b0);
    chk("async_in_ready", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_no_done", frame_done, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_abort", in_ready, 1'b1);
    send(4'b1001, 5'b01111, 1'b0, 1'b0);
    wait_done(FLEN);
    idle_check();

    m1 = model(4'b0110, 5'b10001, 1);
    in_valid1 = 1'b1; d1 = 4'b0110; value_to_pay1 = 5'b10001; p_n1 = 1'b0;
    @(posedge clk); #1;
    in_valid1 = 1'b0; d1 = '0; value_to_pay1 = '0;
    for (int i = 0; i < 38; i++) begin
      @(negedge clk);
      chk("small_active", bar_active1, 1'b1);
      chk("small_bar_out", bar_out1, m1[i]);
      chk("small_done", frame_done1, i == 37);
    end
    @(negedge clk);
    chk("small_idle", bar_active1, 1'b0);
    chk("small_ready", in_ready1, 1'b1);
    chk("small_no_reject", reject1, 1'b0);

    chk("queue_drained", q0.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/barcode_frame_serializer.md
Name: barcode_frame_serializer

Overview:
- Downstream consumer of the pricing/ticket stage; takes its per-transaction result (ValueToPay, D, P_) and emits a serial bar/space pattern.
- The pattern drives the barcode printer/LED strip. It is one framed barcode per accepted transaction, with quiet zones, start/stop guards and a parity bit.
- Valid/ready handshake on the input; module-timed serial output.

Parameters:
- MODULE_CYCLES, 4, clock cycles per bar module (≥1).
- QUIET_MODULES, 2, number of space modules before and after each frame (≥1).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  reset.
- in_valid  input  1  transaction present on value_to_pay/d/p_n.
- in_ready  output  1  block can accept a transaction.
- value_to_pay  input  5  amount code from pricing stage (ValueToPay).
- d  input  4  duration/tariff code from pricing stage (D).
- p_n  input  1  active-low "payment required" flag (P_).
- bar_out  output  1  1 = bar, 0 = space.
- bar_active  output  1  high while a frame, including its quiet zones, is being emitted.
- frame_done  output  1  one-cycle pulse on the last cycle of a frame.
- reject  output  1  one-cycle pulse when an accepted transaction has p_n=1.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (rst_n). While rst_n=0: state IDLE, bar_out=0, bar_active=0, frame_done=0, reject=0, in_ready=0, all counters 0.
- in_ready=1 only in IDLE with rst_n deasserted.
- A handshake occurs on a cycle with in_valid=1 and in_ready=1. On that cycle the block captures d, value_to_pay and p_n.
- If captured p_n=1:
  - reject pulses on the next cycle.
  - The block stays in IDLE and no frame is emitted.
  - in_ready stays 1.
- If captured p_n=0, the frame starts on the next cycle. Frame sequence, in modules:
  - QUIET_MODULES × 0.
  - Start guard 1,0,1.
  - 10 data symbols.
  - Stop guard 1,0,1.
  - QUIET_MODULES × 0.
- Data symbol order, MSB first: d[3..0], value_to_pay[4..0], then a parity bit.
- Parity is even over those 9 bits: the parity bit is 1 when the count of ones is odd.
- Symbol encoding: bit 1 = modules 1,1,0; bit 0 = modules 1,0,0.
- Frame length is (2·QUIET_MODULES+36) modules = (2·QUIET_MODULES+36)·MODULE_CYCLES cycles. With defaults this is 160 cycles.
- Each module holds bar_out constant for exactly MODULE_CYCLES cycles. bar_out is registered.
- bar_active=1 for every frame cycle and 0 otherwise.
- State machine: IDLE → QUIET_PRE → START → DATA → STOP → QUIET_POST → IDLE.
  - Sub-counters: module-cycle counter 0..MODULE_CYCLES-1; module index within the state; symbol index 0..9.
  - Each counter wraps to 0 on a state or symbol change.
- frame_done=1 on the final cycle of QUIET_POST. The next cycle is IDLE with in_ready=1.
- Back-to-back: with in_valid held high, the next handshake is on the first IDLE cycle, so there is exactly one idle cycle between frames.
- in_valid is ignored outside IDLE. Input changes during a frame do not affect it.
- Reset asserted mid-frame aborts immediately to the reset values. No frame_done is produced. After release, in_ready=1 on the first clock edge.
- Latency: handshake at cycle N → bar_active=1 from cycle N+1. The first start-guard bar begins at N+1+QUIET_MODULES·MODULE_CYCLES.

Test Plan:
- Reset, then d=4'b0101, value_to_pay=5'b10011, p_n=0, one-cycle in_valid. Required response:
  - Data bits 0,1,0,1,1,0,0,1,1,1 (parity=1).
  - bar_out module stream 00 101 100 110 100 110 110 100 100 110 110 110 101 00, 4 cycles per module.
  - frame_done exactly 160 cycles after the handshake.
  - in_ready=1 the following cycle.
- d=4'b0000, value_to_pay=5'b00000 → parity 0; data region is ten 1,0,0 symbols; total 160 cycles.
- p_n=1 with in_valid → reject pulses once; bar_active stays 0; in_ready stays 1.
- in_valid held high with two different payloads → two complete frames, one idle cycle between them. The second frame's content matches the payload present on its own handshake cycle.
- rst_n pulled low at cycle 50 of a frame:
  - bar_out and bar_active go 0 asynchronously.
  - No frame_done.
  - A new transaction after release produces a correct full frame.
- MODULE_CYCLES=1, QUIET_MODULES=1 → frame is 38 cycles; guard and symbol patterns unchanged.
